// File: rtl/change_dispenser.sv
// Coin-return driver: greedy 5/2/1 change ejection with per-tube stock
// tracking, timed solenoid pulses and a done/shortfall report.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int TUBE_DEPTH   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       refill,
    output logic       eject5,
    output logic       eject2,
    output logic       eject1,
    output logic       busy,
    output logic       done,
    output logic       shortfall,
    output logic [7:0] remaining,
    output logic [3:0] tube5_cnt,
    output logic [3:0] tube2_cnt,
    output logic [3:0] tube1_cnt
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    FULL       = 4'(TUBE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        C_NONE,
        C_5,
        C_2,
        C_1
    } coin_t;

    state_t        state_q, state_d;
    coin_t         coin_q, coin_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    rem_q, rem_d;
    logic [3:0]    t5_q, t5_d;
    logic [3:0]    t2_q, t2_d;
    logic [3:0]    t1_q, t1_d;
    logic          short_q, short_d;

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        t5_d    = t5_q;
        t2_d    = t2_q;
        t1_d    = t1_q;
        short_d = short_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = amount;
                    state_d = S_SELECT;
                end else if (refill) begin
                    t5_d = FULL;
                    t2_d = FULL;
                    t1_d = FULL;
                end
            end
            S_SELECT: begin
                timer_d = '0;
                // Greedy: largest coin that fits and is still in stock
                if (rem_q == 8'd0) begin
                    short_d = 1'b0;
                    state_d = S_FINISH;
                end else if (rem_q >= 8'd5 && t5_q != 4'd0) begin
                    coin_d  = C_5;
                    rem_d   = rem_q - 8'd5;
                    t5_d    = t5_q - 4'd1;
                    state_d = S_EJECT;
                end else if (rem_q >= 8'd2 && t2_q != 4'd0) begin
                    coin_d  = C_2;
                    rem_d   = rem_q - 8'd2;
                    t2_d    = t2_q - 4'd1;
                    state_d = S_EJECT;
                end else if (t1_q != 4'd0) begin
                    coin_d  = C_1;
                    rem_d   = rem_q - 8'd1;
                    t1_d    = t1_q - 4'd1;
                    state_d = S_EJECT;
                end else begin
                    short_d = 1'b1;
                    state_d = S_FINISH;
                end
            end
            S_EJECT: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = '0;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_SELECT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            coin_q  <= C_NONE;
            timer_q <= '0;
            rem_q   <= 8'd0;
            t5_q    <= FULL;
            t2_q    <= FULL;
            t1_q    <= FULL;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            t5_q    <= t5_d;
            t2_q    <= t2_d;
            t1_q    <= t1_d;
            short_q <= short_d;
        end
    end

    assign eject5    = (state_q == S_EJECT) && (coin_q == C_5);
    assign eject2    = (state_q == S_EJECT) && (coin_q == C_2);
    assign eject1    = (state_q == S_EJECT) && (coin_q == C_1);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign shortfall = (state_q == S_FINISH) && short_q;
    assign remaining = rem_q;
    assign tube5_cnt = t5_q;
    assign tube2_cnt = t2_q;
    assign tube1_cnt = t1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy model predicts each
// coin and final report; a negedge monitor checks pulses and done.
module tb_change_dispenser;

    localparam int PULSE = 4;
    localparam int GAP   = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] amount;
    logic       refill;
    logic       eject5, eject2, eject1;
    logic       busy, done, shortfall;
    logic [7:0] remaining;
    logic [3:0] tube5_cnt, tube2_cnt, tube1_cnt;

    change_dispenser #(
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .TUBE_DEPTH  (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .amount   (amount),
        .refill   (refill),
        .eject5   (eject5),
        .eject2   (eject2),
        .eject1   (eject1),
        .busy     (busy),
        .done     (done),
        .shortfall(shortfall),
        .remaining(remaining),
        .tube5_cnt(tube5_cnt),
        .tube2_cnt(tube2_cnt),
        .tube1_cnt(tube1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sf;
        int rem;
        int t5;
        int t2;
        int t1;
    } res_t;

    int   coin_q[$];
    res_t res_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   m5, m2, m1;
    bit   mon_en;

    task automatic chk(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: per-eject coin order, pulse width, off-time and final report
    logic [2:0] prev_ej;
    int         run_len, off_len, exp_coin;
    bit         have_prev;
    res_t       r;

    function automatic int coin_of(input logic [2:0] e);
        case (e)
            3'b100:  return 5;
            3'b010:  return 2;
            3'b001:  return 1;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [2:0] cur;
        cur = {eject5, eject2, eject1};
        if (!mon_en) begin
            prev_ej   = 3'b000;
            run_len   = 0;
            off_len   = 0;
            have_prev = 1'b0;
        end else begin
            if (cur != 3'b000) chk("onehot", $countones(cur), 1);
            if (cur != 3'b000 && prev_ej == 3'b000) begin
                if (coin_q.size() == 0) begin
                    chk("extra_eject", 1, 0);
                end else begin
                    exp_coin = coin_q.pop_front();
                    chk("coin", coin_of(cur), exp_coin);
                end
                if (have_prev) chk("offtime", off_len, GAP + 1);
                run_len = 1;
            end else if (cur != 3'b000) begin
                run_len++;
            end
            if (cur == 3'b000 && prev_ej != 3'b000) begin
                chk("pulse", run_len, PULSE);
                have_prev = 1'b1;
                off_len   = 1;
            end else if (cur == 3'b000) begin
                off_len++;
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("extra_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("shortfall", int'(shortfall), r.sf);
                    chk("remaining", int'(remaining), r.rem);
                    chk("tube5", int'(tube5_cnt), r.t5);
                    chk("tube2", int'(tube2_cnt), r.t2);
                    chk("tube1", int'(tube1_cnt), r.t1);
                end
                chk("coins_left", coin_q.size(), 0);
                have_prev = 1'b0;
            end
            prev_ej = cur;
        end
    end

    task automatic chk_tubes(input string tag);
        chk({tag, "_t5"}, int'(tube5_cnt), m5);
        chk({tag, "_t2"}, int'(tube2_cnt), m2);
        chk({tag, "_t1"}, int'(tube1_cnt), m1);
    endtask

    // Model the greedy dispense, queue expectations, run and wait for done
    task automatic dispense(input int amt, input bit inject, input bit rf_same);
        int   rem;
        int   n;
        int   cyc;
        res_t e;
        rem = amt;
        n   = 0;
        forever begin
            if (rem >= 5 && m5 > 0) begin
                coin_q.push_back(5); rem -= 5; m5--;
            end else if (rem >= 2 && m2 > 0) begin
                coin_q.push_back(2); rem -= 2; m2--;
            end else if (rem >= 1 && m1 > 0) begin
                coin_q.push_back(1); rem -= 1; m1--;
            end else begin
                break;
            end
            n++;
        end
        e.sf  = (rem != 0) ? 1 : 0;
        e.rem = rem;
        e.t5  = m5;
        e.t2  = m2;
        e.t1  = m1;
        res_q.push_back(e);
        @(negedge clk);
        amount = 8'(amt);
        start  = 1'b1;
        refill = rf_same;
        @(negedge clk);
        start  = 1'b0;
        refill = 1'b0;
        cyc    = 0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (inject && cyc == 3) begin
                start  = 1'b1;
                refill = 1'b1;
                amount = 8'd99;
            end else begin
                start  = 1'b0;
                refill = 1'b0;
            end
        end
        start  = 1'b0;
        refill = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        chk("latency", cyc, 9 * n + 1);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic do_refill();
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        m5 = 15;
        m2 = 15;
        m1 = 15;
        chk_tubes("refill");
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        amount = 8'd0;
        refill = 1'b0;
        mon_en = 1'b0;
        m5 = 15;
        m2 = 15;
        m1 = 15;
        repeat (2) @(negedge clk);
        chk("rst_ej", int'({eject5, eject2, eject1}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sf", int'(shortfall), 0);
        chk("rst_rem", int'(remaining), 0);
        chk_tubes("rst");
        rst    = 1'b0;
        mon_en = 1'b1;

        dispense(8, 1'b0, 1'b0);
        dispense(0, 1'b0, 1'b0);
        dispense(70, 1'b0, 1'b0);
        dispense(5, 1'b0, 1'b0);
        do_refill();
        for (int i = 0; i < 15; i++) dispense(3, 1'b0, 1'b0);
        dispense(3, 1'b0, 1'b0);
        chk("held_rem", int'(remaining), 3);
        dispense(7, 1'b0, 1'b0);
        dispense(1, 1'b0, 1'b1);
        do_refill();
        dispense(8, 1'b1, 1'b0);

        mon_en = 1'b0;
        @(negedge clk);
        amount = 8'd8;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_ej5", int'(eject5), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_ej", int'({eject5, eject2, eject1}), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_rem", int'(remaining), 0);
        m5 = 15;
        m2 = 15;
        m1 = 15;
        chk_tubes("mr");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        dispense(8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("res_left", res_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
